// File: rtl/bcd_xs3_pkg.sv
// bcd_xs3_pkg: shared state encoding and constants for the serial BCD <-> Excess-3 converters
//   state_t         3-bit state (bit index, carry): S0, S1C0, S1C1, S2C0, S2C1, S3C0, S3C1
//   EXCESS3_OFFSET  value added to a BCD digit to form Excess-3
//   BCD_MAX         largest legal BCD digit
package bcd_xs3_pkg;
  typedef enum logic [2:0] {
    S0   = 3'd0,
    S1C0 = 3'd1,
    S1C1 = 3'd2,
    S2C0 = 3'd3,
    S2C1 = 3'd4,
    S3C0 = 3'd5,
    S3C1 = 3'd6
  } state_t;
  localparam logic [3:0] EXCESS3_OFFSET = 4'd3;
  localparam logic [3:0] BCD_MAX = 4'd9;
  function automatic logic carry_of(state_t s);
    return (s == S1C1) || (s == S2C1) || (s == S3C1);
  endfunction
endpackage

// File: rtl/serial_digit_capture.sv
// serial_digit_capture: 4-bit LSB-first serial-to-parallel digit capture with one-cycle valid pulse
//   Clk, Rst  clock, synchronous active-high reset
//   Bit       serial input bit
//   Shift     Bit is accepted this cycle
//   Last      Bit is the 4th (MSB) bit of the digit; loads Digit
//   Digit     last completed digit, registered
//   Valid     pulses the cycle after Digit loads
module serial_digit_capture (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Bit,
  input  logic       Shift,
  input  logic       Last,
  output logic [3:0] Digit,
  output logic       Valid
);
  // only the three earlier bits need holding; the MSB arrives with Last
  logic [2:0] sr;
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sr <= '0;
      Digit <= '0;
      Valid <= 1'b0;
    end else begin
      Valid <= Shift & Last;
      if (Shift) sr <= {Bit, sr[2:1]};
      if (Shift & Last) Digit <= {Bit, sr};
    end
  end
endmodule

// File: rtl/bcd_to_excess3_serial.sv
// bcd_to_excess3_serial: serial LSB-first BCD to Excess-3 Mealy converter with digit capture and count
//   Clk, Rst    clock, synchronous active-high reset
//   X, En       serial BCD bit and its valid strobe
//   Z           Mealy Excess-3 bit for X (0 when En=0 or Rst=1)
//   DigitOut    last completed Excess-3 digit; DigitValid pulses the cycle after it loads
//   DigitCount  completed digits since reset, wraps modulo 2**CNT_W
//   Err         sticky non-BCD input flag when built with BCD_CHECK_EN, otherwise 0
module bcd_to_excess3_serial
  import bcd_xs3_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             X,
  input  logic             En,
  output logic             Z,
  output logic [3:0]       DigitOut,
  output logic             DigitValid,
  output logic [CNT_W-1:0] DigitCount,
  output logic             Err
);
  state_t state_q, state_d, nxt;
  logic c, z_raw, bad, accept;
  assign c = carry_of(state_q);
  // addend bits LSB first are 1,1,0,0; carry tracks the running sum
  always_comb begin
    nxt = S0;
    z_raw = 1'b0;
    bad = 1'b0;
    case (state_q)
      S0: begin
        z_raw = ~X;
        nxt = X ? S1C1 : S1C0;
      end
      S1C0, S1C1: begin
        z_raw = ~(X ^ c);
        nxt = (X | c) ? S2C1 : S2C0;
      end
      S2C0, S2C1: begin
        z_raw = X ^ c;
        nxt = (X & c) ? S3C1 : S3C0;
      end
      S3C0, S3C1: z_raw = X ^ c;
      default: bad = 1'b1;
    endcase
    state_d = (En | bad) ? nxt : state_q;
  end
  assign Z = En & ~Rst & z_raw;
  assign accept = En & ((state_q == S3C0) | (state_q == S3C1));
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S0;
      DigitCount <= '0;
    end else begin
      state_q <= state_d;
      if (accept) DigitCount <= DigitCount + CNT_W'(1);
    end
  end
  serial_digit_capture u_z (
    .Clk(Clk), .Rst(Rst), .Bit(z_raw), .Shift(En), .Last(accept),
    .Digit(DigitOut), .Valid(DigitValid)
  );
`ifdef BCD_CHECK_EN
  logic [3:0] x_digit;
  logic x_valid, x_bad, err_q;
  serial_digit_capture u_x (
    .Clk(Clk), .Rst(Rst), .Bit(X), .Shift(En), .Last(accept),
    .Digit(x_digit), .Valid(x_valid)
  );
  // x_valid coincides with DigitValid, so Err rises together with the bad digit
  assign x_bad = x_valid & (x_digit > BCD_MAX);
  always_ff @(posedge Clk) begin
    if (Rst) err_q <= 1'b0;
    else if (x_bad) err_q <= 1'b1;
  end
  assign Err = err_q | x_bad;
`else
  assign Err = 1'b0;
`endif
endmodule
